quad_encoder_gen: RTL and testbench
===================================

Name: quad_encoder_gen

Overview:
- Motor-plus-encoder plant emulator for the DC motor position loop.
- Consumes the controller's H-bridge outputs (two direction lines, 18-bit duty) and generates the matching quadrature pair and home-switch signal the controller reads back.
- Used in closed-loop simulation and in on-FPGA loopback bring-up without a physical motor.
- Core: a duty-driven phase accumulator that emits spaced quadrature steps and tracks the resulting shaft position.

Parameters:
- ACC_W, 24: phase accumulator width; step rate = duty / 2^ACC_W steps per clock.
- DEAD_DUTY, 1024: duty values below this produce no motion (stiction).
- MIN_GAP, 4: minimum clocks between consecutive QA/QB edges; must be ≥ 3 so the 3-stage input synchroniser of the decoder sees every state.
- INIT_POS, 16'd4000: position value loaded at reset.
- HOME_POS, 16'd3000: home switch asserts when position ≤ this value.
- TAU_SHIFT, 4: inertia filter shift; used only with INERTIA_EN.
- TICK_DIV, 50000: clocks per inertia filter update (1 ms at 50 MHz); used only with INERTIA_EN.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  plant enable; 0 freezes all motion.
- dir1  in  1  H-bridge direction line 1.
- dir2  in  1  H-bridge direction line 2.
- duty  in  18  PWM duty magnitude, unsigned.
- qa  out  1  quadrature channel A.
- qb  out  1  quadrature channel B.
- zdc  out  1  home switch, active-low (0 = at or past home).
- pos  out  16  emulated shaft position, unsigned, wraps.
- step_strobe  out  1  one-clock pulse on each emitted quadrature edge.

Behaviour:
- Reset (rst_n = 0 at a clk_50 edge):
  - qa = 0, qb = 0, pos = INIT_POS, step_strobe = 0.
  - Accumulator = 0, pending = 0, gap counter = 0.
  - zdc recomputed from pos (INIT_POS > HOME_POS gives zdc = 1).
  - Reset mid-step abandons any pending step.
- Drive decode:
  - dir1 = 1, dir2 = 0: forward.
  - dir1 = 0, dir2 = 1: reverse.
  - dir1 == dir2: brake; accumulator and pending cleared, no steps.
- Effective rate:
  - rate = 0 if duty < DEAD_DUTY or brake or en = 0; otherwise rate = duty, zero-extended to ACC_W.
  - With INERTIA_EN defined, rate comes from the inertia filter (see Optional Feature).
- Accumulator:
  - Each clock: acc <= acc + rate, modulo 2^ACC_W.
  - Carry out sets pending.
  - Pending saturates at 1; extra carries while pending is set are dropped.
- Step emission:
  - Condition: pending = 1 and gap counter ≥ MIN_GAP-1.
  - Action, in that clock: advance the {qa,qb} state one position, clear pending, reset gap counter to 0, pulse step_strobe.
  - Otherwise the gap counter increments, saturating at MIN_GAP-1.
- Quadrature state order ({qa,qb}):
  - Forward: 00 → 01 → 11 → 10 → 00 (B leads). pos increments by 1 per step.
  - Reverse: 00 → 10 → 11 → 01 → 00. pos decrements by 1 per step.
- Direction reversal:
  - Takes effect on the next emitted step.
  - The quadrature state walks backward from its current value; no state skip, no glitch.
- pos:
  - Wraps 16'hFFFF ↔ 16'h0000.
  - Updates in the same clock as the qa/qb change.
- zdc:
  - Registered; zdc = 0 when pos ≤ HOME_POS (unsigned compare), else 1.
  - Latency: 1 clock after the pos change.
- Throughput limit:
  - Maximum duty 2^18-1 gives about 1 carry per 64 clocks, so MIN_GAP never throttles at defaults.
  - MIN_GAP throttles only if ACC_W is reduced.
- en = 0: hold qa, qb, pos and acc; pending is retained.

Optional Feature:
- Macro: INERTIA_EN.
- Defined:
  - A signed 19-bit speed register tracks the commanded signed duty (forward +duty, reverse −duty, brake 0).
  - Update every TICK_DIV clocks: speed <= speed + ((cmd − speed) >>> TAU_SHIFT).
  - rate = |speed| when |speed| ≥ DEAD_DUTY; step direction = sign(speed).
  - Brake decays speed toward 0 instead of stopping instantly.
  - Speed resets to 0.
- Undefined: rate follows duty in the same clock; no speed register; TAU_SHIFT and TICK_DIV unused.

Decomposition:
- Package quad_enc_pkg:
  - typedef drive_t enum {DRV_BRAKE, DRV_FWD, DRV_REV}.
  - typedef quad_t logic[1:0].
  - functions quad_next_fwd, quad_next_rev.
  - constant DUTY_W = 18.
- One sub-module, quad_step_sequencer: holds the pending flag, gap counter, quadrature state register and pos counter.
- The top level holds drive decode, the accumulator and the optional inertia filter.

Test Plan:
- Reset with rst_n low for 3 clocks → qa = qb = 0, pos = 4000, zdc = 1, step_strobe = 0.
- Forward, duty = 2^18-1, 6400 clocks → exactly 100 steps, pos = 4100, sequence 00, 01, 11, 10 repeating, edges ≥ 64 clocks apart.
- Reverse, duty = 2^17, from pos 3010 → zdc falls 1 clock after pos reaches 3000; pos keeps decrementing.
- duty = 1000 (below DEAD_DUTY) in either direction, or dir1 = dir2 = 1 with max duty → no qa/qb change for 10000 clocks, accumulator observed 0.
- Reversal: flip dir between steps at {qa,qb} = 11 → next state 01 (not 10), pos decrements, no double edge.
- Wrap: force INIT_POS = 16'hFFFE, forward 3 steps → pos = 16'h0001; with ACC_W = 12 and max duty, edge spacing = MIN_GAP (4) clocks and extra carries are dropped.

Source files
------------

// File: rtl/quad_encoder_gen_pkg.sv
// Shared types and quadrature helpers for the quad_encoder_gen plant emulator.
package quad_enc_pkg;

    localparam int DUTY_W = 18;

    typedef enum logic [1:0] {
        DRV_BRAKE = 2'd0,
        DRV_FWD   = 2'd1,
        DRV_REV   = 2'd2
    } drive_t;

    typedef logic [1:0] quad_t;

    // {qa,qb} forward order 00 -> 01 -> 11 -> 10 (B leads A)
    function automatic quad_t quad_next_fwd(input quad_t q);
        case (q)
            2'b00:   quad_next_fwd = 2'b01;
            2'b01:   quad_next_fwd = 2'b11;
            2'b11:   quad_next_fwd = 2'b10;
            default: quad_next_fwd = 2'b00;
        endcase
    endfunction

    function automatic quad_t quad_next_rev(input quad_t q);
        case (q)
            2'b00:   quad_next_rev = 2'b10;
            2'b10:   quad_next_rev = 2'b11;
            2'b11:   quad_next_rev = 2'b01;
            default: quad_next_rev = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/quad_encoder_gen_step_sequencer.sv
// Turns accumulator carries into spaced quadrature steps and tracks shaft position.
module quad_step_sequencer
    import quad_enc_pkg::*;
#(
    parameter int          MIN_GAP  = 4,
    parameter logic [15:0] INIT_POS = 16'd4000
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clear,
    input  logic        carry,
    input  logic        fwd,
    output quad_t       quad,
    output logic [15:0] pos,
    output logic        step_strobe
);

    localparam int                 GAP_W   = $clog2(MIN_GAP) + 1;
    localparam logic [GAP_W-1:0]   GAP_MAX = GAP_W'(MIN_GAP - 1);

    logic             pending_reg;
    logic [GAP_W-1:0] gap_reg;
    quad_t            quad_reg;
    logic [15:0]      pos_reg;
    logic             strobe_reg;
    logic             step_fire;

    assign step_fire = en && !clear && pending_reg && (gap_reg >= GAP_MAX);

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            gap_reg     <= '0;
            quad_reg    <= 2'b00;
            pos_reg     <= INIT_POS;
            strobe_reg  <= 1'b0;
        end else begin
            strobe_reg <= step_fire;
            // Pending saturates: a carry arriving while a step is still owed is dropped.
            if (clear || step_fire)
                pending_reg <= 1'b0;
            else if (carry)
                pending_reg <= 1'b1;

            if (step_fire) begin
                gap_reg  <= '0;
                quad_reg <= fwd ? quad_next_fwd(quad_reg) : quad_next_rev(quad_reg);
                pos_reg  <= fwd ? pos_reg + 16'd1 : pos_reg - 16'd1;
            end else if (gap_reg < GAP_MAX) begin
                gap_reg <= gap_reg + GAP_W'(1);
            end
        end
    end

    assign quad        = quad_reg;
    assign pos         = pos_reg;
    assign step_strobe = strobe_reg;

endmodule

// File: rtl/quad_encoder_gen.sv
// DC motor + quadrature encoder plant emulator: H-bridge drive in, qa/qb/home switch out.
// Optional macro INERTIA_EN replaces the instant duty-to-rate path with a first-order speed filter.
module quad_encoder_gen
    import quad_enc_pkg::*;
#(
    parameter int          ACC_W     = 24,
    parameter int          DEAD_DUTY = 1024,
    parameter int          MIN_GAP   = 4,
    parameter logic [15:0] INIT_POS  = 16'd4000,
    parameter logic [15:0] HOME_POS  = 16'd3000,
    parameter int          TAU_SHIFT = 4,
    parameter int          TICK_DIV  = 50000
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        en,
    input  logic        dir1,
    input  logic        dir2,
    input  logic [17:0] duty,
    output logic        qa,
    output logic        qb,
    output logic        zdc,
    output logic [15:0] pos,
    output logic        step_strobe
);

    localparam logic [DUTY_W-1:0] DEAD_THR = DUTY_W'(DEAD_DUTY);

    drive_t           drive;
    logic [ACC_W-1:0] rate;
    logic             step_fwd;
    logic             seq_clear;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   acc_sum;
    logic             carry;
    logic             zdc_reg;
    quad_t            quad;

    always_comb begin
        case ({dir1, dir2})
            2'b10:   drive = DRV_FWD;
            2'b01:   drive = DRV_REV;
            default: drive = DRV_BRAKE;
        endcase
    end

`ifdef INERTIA_EN
    localparam int                TICK_W    = $clog2(TICK_DIV) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DUTY_W:0]   DEAD_MAG  = (DUTY_W + 1)'(DEAD_DUTY);

    logic signed [DUTY_W:0]   speed_reg;
    logic signed [DUTY_W:0]   cmd;
    logic signed [DUTY_W+1:0] delta;
    logic signed [DUTY_W+1:0] delta_scaled;
    logic [DUTY_W:0]          speed_mag;
    logic [TICK_W-1:0]        tick_reg;

    always_comb begin
        case (drive)
            DRV_FWD: cmd = $signed({1'b0, duty});
            DRV_REV: cmd = -$signed({1'b0, duty});
            default: cmd = '0;
        endcase
        delta        = $signed({cmd[DUTY_W], cmd}) - $signed({speed_reg[DUTY_W], speed_reg});
        delta_scaled = delta >>> TAU_SHIFT;
        speed_mag    = speed_reg[DUTY_W] ? (DUTY_W + 1)'(-speed_reg) : speed_reg;
        rate         = (en && speed_mag >= DEAD_MAG) ? ACC_W'(speed_mag) : '0;
        step_fwd     = !speed_reg[DUTY_W];
        seq_clear    = 1'b0;
    end

    // Speed moves a 1/2^TAU_SHIFT fraction toward the command once per tick.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            speed_reg <= '0;
            tick_reg  <= '0;
        end else if (en) begin
            if (tick_reg == TICK_LAST) begin
                tick_reg  <= '0;
                speed_reg <= speed_reg + delta_scaled[DUTY_W:0];
            end else begin
                tick_reg <= tick_reg + TICK_W'(1);
            end
        end
    end
`else
    always_comb begin
        rate      = (en && drive != DRV_BRAKE && duty >= DEAD_THR) ? ACC_W'(duty) : '0;
        step_fwd  = (drive != DRV_REV);
        seq_clear = (drive == DRV_BRAKE);
    end
`endif

    assign acc_sum = {1'b0, acc_reg} + {1'b0, rate};
    assign carry   = acc_sum[ACC_W];

    always_ff @(posedge clk_50) begin
        if (!rst_n)
            acc_reg <= '0;
        else if (seq_clear)
            acc_reg <= '0;
        else if (en)
            acc_reg <= acc_sum[ACC_W-1:0];
    end

    quad_step_sequencer #(
        .MIN_GAP  (MIN_GAP),
        .INIT_POS (INIT_POS)
    ) u_seq (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .en          (en),
        .clear       (seq_clear),
        .carry       (carry),
        .fwd         (step_fwd),
        .quad        (quad),
        .pos         (pos),
        .step_strobe (step_strobe)
    );

    // Home switch lags pos by one clock, like a real registered input stage.
    always_ff @(posedge clk_50) begin
        if (!rst_n)
            zdc_reg <= (INIT_POS > HOME_POS);
        else
            zdc_reg <= (pos > HOME_POS);
    end

    assign qa  = quad[1];
    assign qb  = quad[0];
    assign zdc = zdc_reg;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Scoreboard bench for quad_encoder_gen: three instances (default, ACC_W=12 near wrap, start near home).
`timescale 1ns/1ps
module tb_quad_encoder_gen;

    logic        clk_50 = 1'b0;
    logic        rst_n1, rst_n2, rst_n3;
    logic        en, dir1, dir2;
    logic [17:0] duty;

    logic        qa1, qb1, zdc1, strobe1;
    logic        qa2, qb2, zdc2, strobe2;
    logic        qa3, qb3, zdc3, strobe3;
    logic [15:0] pos1, pos2, pos3;

    always #10 clk_50 = ~clk_50;

    quad_encoder_gen u_dut1 (
        .clk_50(clk_50), .rst_n(rst_n1), .en(en), .dir1(dir1), .dir2(dir2), .duty(duty),
        .qa(qa1), .qb(qb1), .zdc(zdc1), .pos(pos1), .step_strobe(strobe1)
    );

    quad_encoder_gen #(.ACC_W(12), .INIT_POS(16'hFFFE)) u_dut2 (
        .clk_50(clk_50), .rst_n(rst_n2), .en(en), .dir1(dir1), .dir2(dir2), .duty(duty),
        .qa(qa2), .qb(qb2), .zdc(zdc2), .pos(pos2), .step_strobe(strobe2)
    );

    quad_encoder_gen #(.INIT_POS(16'd3010)) u_dut3 (
        .clk_50(clk_50), .rst_n(rst_n3), .en(en), .dir1(dir1), .dir2(dir2), .duty(duty),
        .qa(qa3), .qb(qb3), .zdc(zdc3), .pos(pos3), .step_strobe(strobe3)
    );

    typedef struct {
        logic [1:0]  quad;
        logic [15:0] pos;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sel = 1;
    int step_count = 0;
    int last_step = -1;
    int min_sp = 1000000;
    int max_sp = 0;

    logic        mon_qa, mon_qb, mon_strobe;
    logic [15:0] mon_pos;

    logic [1:0] fwd_seq [4];
    logic [1:0] rev_seq [4];

    always @(posedge clk_50) cyc <= cyc + 1;

    always_comb begin
        mon_qa = qa1; mon_qb = qb1; mon_pos = pos1; mon_strobe = strobe1;
        case (sel)
            2: begin mon_qa = qa2; mon_qb = qb2; mon_pos = pos2; mon_strobe = strobe2; end
            3: begin mon_qa = qa3; mon_qb = qb3; mon_pos = pos3; mon_strobe = strobe3; end
            default: ;
        endcase
    end

    // Every step pulse on the selected instance is matched against the next queued expectation.
    always @(negedge clk_50) begin
        if (mon_strobe) begin
            checks++;
            step_count++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_step dut=%0d got quad=%b pos=%0d required no step", sel, {mon_qa, mon_qb}, mon_pos);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mon_qa, mon_qb} !== mon_e.quad || mon_pos !== mon_e.pos) begin
                    failures++;
                    $display("FAIL step dut=%0d got quad=%b pos=%0d required quad=%b pos=%0d", sel, {mon_qa, mon_qb}, mon_pos, mon_e.quad, mon_e.pos);
                end else begin
                    $display("step dut=%0d quad=%b pos=%0d ok", sel, {mon_qa, mon_qb}, mon_pos);
                end
            end
            if (last_step >= 0) begin
                if (cyc - last_step < min_sp) min_sp = cyc - last_step;
                if (cyc - last_step > max_sp) max_sp = cyc - last_step;
            end
            last_step = cyc;
        end
    end

    task automatic reset_monitor(input int which);
        sel = which;
        step_count = 0;
        last_step = -1;
        min_sp = 1000000;
        max_sp = 0;
    endtask

    task automatic push_steps(input int n, input logic fwd, input int start_idx, input logic [15:0] start_pos);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            e.quad = fwd ? fwd_seq[(start_idx + i) % 4] : rev_seq[(start_idx + i) % 4];
            e.pos  = fwd ? start_pos + 16'(i) : start_pos - 16'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_50); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout got %0d steps outstanding after %0d clocks required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n1 = 1'b0; rst_n2 = 1'b0; rst_n3 = 1'b0;
        en = 1'b0; dir1 = 1'b0; dir2 = 1'b0; duty = '0;
        repeat (3) @(negedge clk_50);
        checks += 6;
        if ({qa1, qb1} !== 2'b00) begin failures++; $display("FAIL reset_quad got %b required 00", {qa1, qb1}); end
        if (pos1 !== 16'd4000) begin failures++; $display("FAIL reset_pos got %0d required 4000", pos1); end
        if (zdc1 !== 1'b1) begin failures++; $display("FAIL reset_zdc got %b required 1", zdc1); end
        if (strobe1 !== 1'b0) begin failures++; $display("FAIL reset_strobe got %b required 0", strobe1); end
        if (u_dut1.acc_reg !== 24'd0) begin failures++; $display("FAIL reset_acc got %0d required 0", u_dut1.acc_reg); end
        if (pos2 !== 16'hFFFE || pos3 !== 16'd3010 || zdc3 !== 1'b1) begin
            failures++;
            $display("FAIL reset_params got pos2=%h pos3=%0d zdc3=%b required FFFE 3010 1", pos2, pos3, zdc3);
        end
        $display("reset pos=%0d zdc=%b quad=%b", pos1, zdc1, {qa1, qb1});
        rst_n1 = 1'b1;
    endtask

    task automatic test_forward();
        reset_monitor(1);
        push_steps(100, 1'b1, 0, 16'd4000);
        en = 1'b1; dir1 = 1'b1; dir2 = 1'b0; duty = 18'h3FFFF;
        wait_drain("forward", 6500);
        dir1 = 1'b0;
        checks += 3;
        if (step_count !== 100) begin failures++; $display("FAIL fwd_count got %0d required 100", step_count); end
        if (pos1 !== 16'd4100 || {qa1, qb1} !== 2'b00) begin
            failures++; $display("FAIL fwd_final got pos=%0d quad=%b required 4100 00", pos1, {qa1, qb1});
        end
        if (min_sp < 64) begin failures++; $display("FAIL fwd_spacing got %0d required >=64", min_sp); end
        $display("forward steps=%0d pos=%0d min_spacing=%0d", step_count, pos1, min_sp);
    endtask

    task automatic test_dead_and_brake();
        logic [1:0]  dirs [3];
        logic [17:0] duties [3];
        dirs[0] = 2'b10; duties[0] = 18'd1000;
        dirs[1] = 2'b01; duties[1] = 18'd1000;
        dirs[2] = 2'b11; duties[2] = 18'h3FFFF;
        reset_monitor(1);
        dir1 = 1'b0; dir2 = 1'b0;
        repeat (4) @(negedge clk_50);
        for (int k = 0; k < 3; k++) begin
            {dir1, dir2} = dirs[k];
            duty = duties[k];
            repeat (10000) @(negedge clk_50);
            checks++;
            if (u_dut1.acc_reg !== 24'd0 || pos1 !== 16'd4100 || {qa1, qb1} !== 2'b00) begin
                failures++;
                $display("FAIL still_%0d got acc=%0d pos=%0d quad=%b required 0 4100 00", k, u_dut1.acc_reg, pos1, {qa1, qb1});
            end else begin
                $display("still case=%0d dir=%b duty=%0d pos=%0d", k, dirs[k], duties[k], pos1);
            end
        end
        dir1 = 1'b0; dir2 = 1'b0;
        @(negedge clk_50);
    endtask

    task automatic test_reversal();
        reset_monitor(1);
        push_steps(2, 1'b1, 0, 16'd4100);
        duty = 18'h3FFFF; dir1 = 1'b1; dir2 = 1'b0;
        wait_drain("rev_pre", 300);
        checks++;
        if ({qa1, qb1} !== 2'b11) begin failures++; $display("FAIL rev_pre_state got %b required 11", {qa1, qb1}); end
        dir1 = 1'b0; dir2 = 1'b1;
        push_steps(2, 1'b0, 2, 16'd4102);
        wait_drain("rev_post", 300);
        dir1 = 1'b0; dir2 = 1'b0;
        checks += 2;
        if (pos1 !== 16'd4100 || step_count !== 4) begin
            failures++; $display("FAIL rev_final got pos=%0d steps=%0d required 4100 4", pos1, step_count);
        end
        if (min_sp < 64) begin failures++; $display("FAIL rev_spacing got %0d required >=64", min_sp); end
        $display("reversal pos=%0d steps=%0d min_spacing=%0d", pos1, step_count, min_sp);
    endtask

    task automatic test_home();
        int n;
        rst_n1 = 1'b0;
        rst_n3 = 1'b1;
        reset_monitor(3);
        push_steps(15, 1'b0, 0, 16'd3010);
        dir1 = 1'b0; dir2 = 1'b1; duty = 18'h20000;
        n = 0;
        while (pos3 !== 16'd3000 && n < 2000) begin
            @(negedge clk_50);
            n++;
        end
        checks += 2;
        if (zdc3 !== 1'b1) begin failures++; $display("FAIL home_lag got zdc=%b at pos=%0d required 1", zdc3, pos3); end
        @(negedge clk_50);
        if (zdc3 !== 1'b0) begin failures++; $display("FAIL home_fall got zdc=%b at pos=%0d required 0", zdc3, pos3); end
        wait_drain("home", 1500);
        dir2 = 1'b0;
        checks++;
        if (pos3 !== 16'd2995 || zdc3 !== 1'b0) begin
            failures++; $display("FAIL home_final got pos=%0d zdc=%b required 2995 0", pos3, zdc3);
        end
        $display("home pos=%0d zdc=%b", pos3, zdc3);
        rst_n3 = 1'b0;
    endtask

    task automatic test_wrap_gap();
        rst_n2 = 1'b1;
        reset_monitor(2);
        push_steps(8, 1'b1, 0, 16'hFFFE);
        dir1 = 1'b1; dir2 = 1'b0; duty = 18'h3FFFF;
        wait_drain("wrap", 200);
        dir1 = 1'b0;
        repeat (20) @(negedge clk_50);
        checks += 2;
        if (min_sp !== 4 || max_sp !== 4) begin
            failures++; $display("FAIL gap_spacing got min=%0d max=%0d required 4 4", min_sp, max_sp);
        end
        if (pos2 !== 16'h0006 || step_count !== 8) begin
            failures++; $display("FAIL wrap_final got pos=%h steps=%0d required 0006 8", pos2, step_count);
        end
        $display("wrap pos=%h steps=%0d spacing=%0d..%0d", pos2, step_count, min_sp, max_sp);
        rst_n2 = 1'b0;
    endtask

    initial begin
        fwd_seq[0] = 2'b00; fwd_seq[1] = 2'b01; fwd_seq[2] = 2'b11; fwd_seq[3] = 2'b10;
        rev_seq[0] = 2'b00; rev_seq[1] = 2'b10; rev_seq[2] = 2'b11; rev_seq[3] = 2'b01;
        test_reset();
        test_forward();
        test_dead_and_brake();
        test_reversal();
        test_home();
        test_wrap_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
